// File: rtl/dmem_bridge.sv
// dmem_bridge: stalls the CPU while it runs a single load/store over a req/ack memory port, with a timeout and sticky error flag
module dmem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);
  state_t      state, state_n;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [7:0]  cnt;
  logic        req;
  logic        misaligned;
  assign req        = cpu_re | cpu_we;
  assign misaligned = cpu_addr[1:0] != 2'b00;
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    stall   = (state == IDLE && req) || state == BUSY;
    mem_req = state == BUSY;
    mem_we  = mem_req & we_q;
    state_n = state == IDLE ? (!req ? IDLE : misaligned ? DONE : BUSY) :
              state == BUSY ? ((mem_ack || cnt == CNT_MAX) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= cpu_addr[31:2];
        wdata_q <= cpu_wdata;
        we_q    <= cpu_we;
        cnt     <= '0;
        if (misaligned) begin
          err       <= 1'b1;
          cpu_rdata <= '0;
        end
      end
      if (state == BUSY) begin
        if (mem_ack) begin
          if (!we_q) cpu_rdata <= mem_rdata;
        end else if (cnt == CNT_MAX) begin
          err       <= 1'b1;
          cpu_rdata <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scoreboard bench for dmem_bridge
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd = '0;

  dmem_bridge #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                        input int ack_at, input logic [31:0] rd, input int exp_stalls,
                        input int exp_reqs, input logic exp_err, input logic exp_mwe);
    int stalls = 0;
    int reqs = 0;
    int n = 0;
    logic [31:0] e;
    e = (a[1:0] != 2'b00 || ack_at == 0) ? 32'h0 : we ? last_rd : rd;
    last_rd = e;
    sb.push_back(e);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_re = re; mem_ack = 1'b0;
    #1;
    while (stall && n < 300) begin
      stalls++;
      if (mem_req) begin
        reqs++;
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(exp_mwe));
        if (we) chk("mem_wdata", mem_wdata, wd);
        mem_ack = reqs == ack_at;
        mem_rdata = mem_ack ? rd : $urandom;
      end
      @(negedge clk);
      cpu_we = 1'b0; cpu_re = 1'b0; mem_ack = 1'b0;
      #1;
      n++;
    end
    chk("bounded", 32'(n < 300), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("req_cycles", 32'(reqs), 32'(exp_reqs));
    chk("done_mem_req", 32'(mem_req), 32'd0);
    chk("done_mem_we", 32'(mem_we), 32'd0);
    chk("err", 32'(err), 32'(exp_err));
    chk("cpu_rdata", cpu_rdata, sb.pop_front());
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access(32'h100, 32'h0, 1'b0, 1'b1, 1, 32'hCAFEF00D, 2, 1, 1'b0, 1'b0);
    access(32'h204, 32'h12345678, 1'b1, 1'b0, 3, 32'hDEADBEEF, 4, 3, 1'b0, 1'b1);
    access(32'h80, 32'h0, 1'b0, 1'b1, 16, 32'h0BADF00D, 17, 16, 1'b0, 1'b0);
    access(32'h40, 32'hA5A5A5A5, 1'b1, 1'b1, 2, 32'h11111111, 3, 2, 1'b0, 1'b1);
    @(negedge clk);
    cpu_addr = 32'h300; cpu_re = 1'b1;
    #1;
    chk("abort_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    cpu_re = 1'b0;
    #1;
    chk("abort_busy1", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy2", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("ack_ignored_req", 32'(mem_req), 32'd0);
    chk("ack_ignored_rdata", cpu_rdata, 32'd0);
    last_rd = '0;
    access(32'h104, 32'h0, 1'b0, 1'b1, 0, 32'h0, 17, 16, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_err", 32'(err), 32'd0);
    last_rd = '0;
    access(32'h103, 32'h0, 1'b0, 1'b1, 1, 32'h77777777, 1, 0, 1'b1, 1'b0);
    access(32'h200, 32'h0, 1'b0, 1'b1, 1, 32'h55AA55AA, 2, 1, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 16, max BUSY cycles without MEM_ACK before abort (legal 2..255).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 CPU_ADDR  input  32  byte address from datapath ALU result.
REQ-005 CPU_WDATA  input  32  store data from register file port B.
REQ-006 CPU_WE  input  1  store request (datapath D_MEM_we).
REQ-007 CPU_RE  input  1  load request from control unit.
REQ-008 CPU_RDATA  output  32  load data returned to write-back mux.
REQ-009 STALL  output  1  freezes PC and register-file write while high.
REQ-010 MEM_REQ  output  1  request to external memory, level, held until acknowledged.
REQ-011 MEM_WE  output  1  1 = write, 0 = read; valid while MEM_REQ=1.
REQ-012 MEM_ADDR  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-013 MEM_WDATA  output  32  latched store data.
REQ-014 MEM_ACK  input  1  external memory completion, one-cycle pulse.
REQ-015 MEM_RDATA  input  32  read data, valid in the cycle MEM_ACK=1.
REQ-016 ERR  output  1  sticky error flag (timeout or misaligned access).

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-018 IDLE with CPU_RE|CPU_WE: latch address, data, direction; STALL=1 combinationally that cycle; next state BUSY.
REQ-019 CPU_WE and CPU_RE both high: SHALL be treated as a write.
REQ-020 IDLE with CPU_ADDR[1:0]!=0 and a request: no external access, ERR set, next state DONE, CPU_RDATA=0.
REQ-021 BUSY: MEM_REQ=1, MEM_WE/MEM_ADDR/MEM_WDATA from latches, stable every BUSY cycle; STALL=1.
REQ-022 BUSY with MEM_ACK=1: for a read, capture MEM_RDATA into CPU_RDATA register; next state DONE.
REQ-023 Timeout counter (8 bit) cleared on BUSY entry, +1 per BUSY cycle without ACK; at count TIMEOUT-1 without ACK: next state DONE, ERR set, CPU_RDATA=0.
REQ-024 ACK in the final permitted BUSY cycle SHALL win over timeout (normal completion, no ERR).
REQ-025 DONE: STALL=0, MEM_REQ=0, CPU_RDATA holds result; next state IDLE unconditionally; requests in DONE are ignored (same instruction).
REQ-026 Minimum access = 2 stall cycles (IDLE detect + one BUSY), result visible in DONE cycle.
REQ-027 MEM_ACK in IDLE or DONE SHALL be ignored, no state change.
REQ-028 Writes SHALL leave CPU_RDATA unchanged.
REQ-029 ERR SHALL remain 1 until RST; later accesses proceed normally.
REQ-030 MEM_REQ, MEM_WE SHALL be 0 in IDLE and DONE.

Reset
REQ-031 RST=1 at an edge: state IDLE, counter 0, ERR 0, CPU_RDATA 0, latches 0; MEM_REQ/MEM_WE 0 from that edge.
REQ-032 RST mid-BUSY SHALL abort the access; a subsequent MEM_ACK is ignored.
REQ-033 STALL SHALL be 0 during reset except as combinationally implied by a request seen in IDLE.

Verification
REQ-034 Read 0x100, ACK with MEM_RDATA=0xCAFEF00D in 1st BUSY cycle -> STALL high 2 cycles, DONE shows CPU_RDATA=0xCAFEF00D, MEM_ADDR=0x100.
REQ-035 Write 0x204 data 0x12345678, ACK after 3 BUSY cycles -> MEM_WE=1, MEM_WDATA=0x12345678 stable 3 cycles, STALL 4 cycles, CPU_RDATA unchanged.
REQ-036 Read, no ACK, TIMEOUT=16 -> MEM_REQ high exactly 16 cycles, ERR=1, CPU_RDATA=0; ACK on 16th cycle instead -> no ERR.
REQ-037 Read at 0x103 -> MEM_REQ never asserted, ERR=1 next cycle, STALL 1 cycle.
REQ-038 RST pulsed in 2nd BUSY cycle, ACK 1 cycle later -> IDLE, MEM_REQ=0, ERR=0, CPU_RDATA=0, ACK ignored.
REQ-039 CPU_RE=CPU_WE=1 at 0x40 -> MEM_WE=1 (write issued).
